// File: rtl/riscv_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, multiplier FSM states
// and the default datapath width.
package riscv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_MUL  = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH steps,
// keeps the low WIDTH bits of the product.
module ex_mul_seq
    import riscv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(WIDTH);

    mul_state_e       r_state;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= MUL_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (i_start) begin
                        r_mcand  <= i_op_a;
                        r_mplier <= i_op_b;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= MUL_BUSY;
                        r_busy   <= 1'b1;
                    end
                end
                MUL_BUSY: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    // Last step retires here; the product is valid during DONE.
                    if (r_count == CNT_W'(WIDTH - 1)) begin
                        r_state <= MUL_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                MUL_DONE: begin
                    r_state <= MUL_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= MUL_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_acc;

endmodule

// File: rtl/pipe_ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, sequential multiply
// with pipeline stall, and the EX/MEM pipeline register.
module pipe_ex_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ALUOP_IN,
    input  logic             ALUSRC_IN,
    input  logic             REGWRITE_IN,
    input  logic             MEMTOREG_IN,
    input  logic             MEMWRITE_IN,
    input  logic             MEMREAD_IN,
    input  logic [4:0]       ARS1_IN,
    input  logic [4:0]       ARS2_IN,
    input  logic [4:0]       ARD_IN,
    input  logic [WIDTH-1:0] RS1_IN,
    input  logic [WIDTH-1:0] RS2_IN,
    input  logic [WIDTH-1:0] IMMEDIATE_IN,
    input  logic             WB_REGWRITE,
    input  logic [4:0]       WB_ARD,
    input  logic [WIDTH-1:0] WB_DATA,
    output logic [WIDTH-1:0] ALURESULT_OUT,
    output logic [WIDTH-1:0] STOREDATA_OUT,
    output logic [4:0]       ARD_OUT,
    output logic             REGWRITE_OUT,
    output logic             MEMTOREG_OUT,
    output logic             MEMWRITE_OUT,
    output logic             MEMREAD_OUT,
    output logic             STALL_OUT
);

    logic [WIDTH-1:0] w_fwd_rs1;
    logic [WIDTH-1:0] w_fwd_rs2;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_exmem_ok;
    logic             w_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    logic             r_mul_regwrite;
    logic             r_mul_memtoreg;
    logic             r_mul_memwrite;
    logic             r_mul_memread;
    logic [4:0]       r_mul_ard;
    logic [WIDTH-1:0] r_mul_store;

    // A load in EX/MEM has no data yet, so it never forwards.
    assign w_exmem_ok = REGWRITE_OUT && !MEMREAD_OUT && (ARD_OUT != 5'd0);

    always_comb begin
        w_fwd_rs1 = RS1_IN;
        if (w_exmem_ok && (ARD_OUT == ARS1_IN)) begin
            w_fwd_rs1 = ALURESULT_OUT;
        end else if (WB_REGWRITE && (WB_ARD != 5'd0) && (WB_ARD == ARS1_IN)) begin
            w_fwd_rs1 = WB_DATA;
        end
    end

    always_comb begin
        w_fwd_rs2 = RS2_IN;
        if (w_exmem_ok && (ARD_OUT == ARS2_IN)) begin
            w_fwd_rs2 = ALURESULT_OUT;
        end else if (WB_REGWRITE && (WB_ARD != 5'd0) && (WB_ARD == ARS2_IN)) begin
            w_fwd_rs2 = WB_DATA;
        end
    end

    assign w_op_b = ALUSRC_IN ? IMMEDIATE_IN : w_fwd_rs2;

    always_comb begin
        w_alu_result = '0;
        case (alu_op_e'(ALUOP_IN))
            ALU_ADD:  w_alu_result = w_fwd_rs1 + w_op_b;
            ALU_SUB:  w_alu_result = w_fwd_rs1 - w_op_b;
            ALU_AND:  w_alu_result = w_fwd_rs1 & w_op_b;
            ALU_OR:   w_alu_result = w_fwd_rs1 | w_op_b;
            ALU_XOR:  w_alu_result = w_fwd_rs1 ^ w_op_b;
            ALU_SLL:  w_alu_result = w_fwd_rs1 << w_op_b[4:0];
            ALU_SRL:  w_alu_result = w_fwd_rs1 >> w_op_b[4:0];
            ALU_SRA:  w_alu_result = WIDTH'($signed(w_fwd_rs1) >>> w_op_b[4:0]);
            ALU_SLT:  w_alu_result = WIDTH'($signed(w_fwd_rs1) < $signed(w_op_b));
            ALU_SLTU: w_alu_result = WIDTH'(w_fwd_rs1 < w_op_b);
            default:  w_alu_result = '0;
        endcase
    end

    // DONE is excluded so the still-held MUL in ID/EX is not accepted twice.
    assign w_start   = (ALUOP_IN == ALU_MUL) && !w_mul_busy && !w_mul_done;
    assign STALL_OUT = rst && (w_start || w_mul_busy);

    ex_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_op_a    (w_fwd_rs1),
        .i_op_b    (w_op_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mul_regwrite <= 1'b0;
            r_mul_memtoreg <= 1'b0;
            r_mul_memwrite <= 1'b0;
            r_mul_memread  <= 1'b0;
            r_mul_ard      <= '0;
            r_mul_store    <= '0;
        end else if (w_start) begin
            r_mul_regwrite <= REGWRITE_IN;
            r_mul_memtoreg <= MEMTOREG_IN;
            r_mul_memwrite <= MEMWRITE_IN;
            r_mul_memread  <= MEMREAD_IN;
            r_mul_ard      <= ARD_IN;
            r_mul_store    <= w_fwd_rs2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALURESULT_OUT <= '0;
            STOREDATA_OUT <= '0;
            ARD_OUT       <= '0;
            REGWRITE_OUT  <= 1'b0;
            MEMTOREG_OUT  <= 1'b0;
            MEMWRITE_OUT  <= 1'b0;
            MEMREAD_OUT   <= 1'b0;
        end else if (w_mul_done) begin
            ALURESULT_OUT <= w_mul_product;
            STOREDATA_OUT <= r_mul_store;
            ARD_OUT       <= r_mul_ard;
            REGWRITE_OUT  <= r_mul_regwrite;
            MEMTOREG_OUT  <= r_mul_memtoreg;
            MEMWRITE_OUT  <= r_mul_memwrite;
            MEMREAD_OUT   <= r_mul_memread;
        end else if (w_start || w_mul_busy) begin
            ALURESULT_OUT <= '0;
            STOREDATA_OUT <= '0;
            ARD_OUT       <= '0;
            REGWRITE_OUT  <= 1'b0;
            MEMTOREG_OUT  <= 1'b0;
            MEMWRITE_OUT  <= 1'b0;
            MEMREAD_OUT   <= 1'b0;
        end else begin
            ALURESULT_OUT <= w_alu_result;
            STOREDATA_OUT <= w_fwd_rs2;
            ARD_OUT       <= ARD_IN;
            REGWRITE_OUT  <= REGWRITE_IN;
            MEMTOREG_OUT  <= MEMTOREG_IN;
            MEMWRITE_OUT  <= MEMWRITE_IN;
            MEMREAD_OUT   <= MEMREAD_IN;
        end
    end

endmodule

// File: tb/tb_pipe_ex_stage.sv
// Directed plus randomized checking of pipe_ex_stage against an instruction-level
// model of the EX/MEM register, forwarding rules and multiply stall timing.
module tb_pipe_ex_stage;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    ALUOP_IN;
    logic          ALUSRC_IN, REGWRITE_IN, MEMTOREG_IN, MEMWRITE_IN, MEMREAD_IN;
    logic [4:0]    ARS1_IN, ARS2_IN, ARD_IN;
    logic [W-1:0]  RS1_IN, RS2_IN, IMMEDIATE_IN;
    logic          WB_REGWRITE;
    logic [4:0]    WB_ARD;
    logic [W-1:0]  WB_DATA;
    logic [W-1:0]  ALURESULT_OUT, STOREDATA_OUT;
    logic [4:0]    ARD_OUT;
    logic          REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT, STALL_OUT;

    pipe_ex_stage #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ALUOP_IN      (ALUOP_IN),
        .ALUSRC_IN     (ALUSRC_IN),
        .REGWRITE_IN   (REGWRITE_IN),
        .MEMTOREG_IN   (MEMTOREG_IN),
        .MEMWRITE_IN   (MEMWRITE_IN),
        .MEMREAD_IN    (MEMREAD_IN),
        .ARS1_IN       (ARS1_IN),
        .ARS2_IN       (ARS2_IN),
        .ARD_IN        (ARD_IN),
        .RS1_IN        (RS1_IN),
        .RS2_IN        (RS2_IN),
        .IMMEDIATE_IN  (IMMEDIATE_IN),
        .WB_REGWRITE   (WB_REGWRITE),
        .WB_ARD        (WB_ARD),
        .WB_DATA       (WB_DATA),
        .ALURESULT_OUT (ALURESULT_OUT),
        .STOREDATA_OUT (STOREDATA_OUT),
        .ARD_OUT       (ARD_OUT),
        .REGWRITE_OUT  (REGWRITE_OUT),
        .MEMTOREG_OUT  (MEMTOREG_OUT),
        .MEMWRITE_OUT  (MEMWRITE_OUT),
        .MEMREAD_OUT   (MEMREAD_OUT),
        .STALL_OUT     (STALL_OUT)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected EX/MEM contents
    logic [31:0] m_res, m_sd;
    logic [4:0]  m_ard;
    logic        m_rw, m_m2r, m_mw, m_mr;
    // Outstanding multiply: cycles of stall left after acceptance, and its result
    bit          m_pend;
    int          m_rem;
    logic [31:0] m_prod, m_msd;
    logic [4:0]  m_mard;
    logic        m_mrw, m_mm2r, m_mmw, m_mmr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sa;
        sa = int'(b % 32);
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << sa;
            4'd6:    r = a >> sa;
            4'd7:    r = 32'($signed(a) >>> sa);
            4'd8:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    r = (a < b) ? 32'd1 : 32'd0;
            4'd10:   r = a * b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] ars, input logic [31:0] rv);
        if (m_rw && !m_mr && ars != 5'd0 && ars == m_ard) return m_res;
        if (WB_REGWRITE && WB_ARD != 5'd0 && WB_ARD == ars) return WB_DATA;
        return rv;
    endfunction

    task automatic model_clear();
        m_res = 0; m_sd = 0; m_ard = 0; m_rw = 0; m_m2r = 0; m_mw = 0; m_mr = 0;
        m_pend = 0; m_rem = 0;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic src, input logic rw, input logic m2r,
                             input logic mw, input logic mr, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                             input logic [31:0] imm);
        ALUOP_IN = op; ALUSRC_IN = src; REGWRITE_IN = rw; MEMTOREG_IN = m2r;
        MEMWRITE_IN = mw; MEMREAD_IN = mr; ARS1_IN = a1; ARS2_IN = a2; ARD_IN = rd;
        RS1_IN = v1; RS2_IN = v2; IMMEDIATE_IN = imm;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
        WB_REGWRITE = en; WB_ARD = rd; WB_DATA = d;
    endtask

    task automatic rand_wb();
        set_wb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
    endtask

    task automatic rand_instr();
        logic [31:0] v2;
        v2 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
        set_instr(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom, v2, $urandom);
        rand_wb();
    endtask

    // One clock of the stage: predict, check stall before the edge, check EX/MEM after it.
    task automatic cycle(output bit stall_obs);
        logic [31:0] a, b, opb, n_res, n_sd;
        logic [4:0]  n_ard;
        logic        n_rw, n_m2r, n_mw, n_mr;
        bit          e_stall;
        #1;
        a = fwd(ARS1_IN, RS1_IN);
        b = fwd(ARS2_IN, RS2_IN);
        opb = ALUSRC_IN ? IMMEDIATE_IN : b;
        n_res = 0; n_sd = 0; n_ard = 0; n_rw = 0; n_m2r = 0; n_mw = 0; n_mr = 0;
        e_stall = 0;
        if (m_pend && m_rem > 0) begin
            e_stall = 1;
            m_rem--;
        end else if (m_pend) begin
            n_res = m_prod; n_sd = m_msd; n_ard = m_mard;
            n_rw = m_mrw; n_m2r = m_mm2r; n_mw = m_mmw; n_mr = m_mmr;
            m_pend = 0;
        end else if (ALUOP_IN == 4'd10) begin
            e_stall = 1;
            m_pend = 1; m_rem = 32;
            m_prod = ref_alu(4'd10, a, opb); m_msd = b; m_mard = ARD_IN;
            m_mrw = REGWRITE_IN; m_mm2r = MEMTOREG_IN; m_mmw = MEMWRITE_IN; m_mmr = MEMREAD_IN;
        end else begin
            n_res = ref_alu(ALUOP_IN, a, opb); n_sd = b; n_ard = ARD_IN;
            n_rw = REGWRITE_IN; n_m2r = MEMTOREG_IN; n_mw = MEMWRITE_IN; n_mr = MEMREAD_IN;
        end
        stall_obs = STALL_OUT;
        chk("stall", 32'(STALL_OUT), 32'(e_stall));
        @(posedge clk);
        #1;
        m_res = n_res; m_sd = n_sd; m_ard = n_ard;
        m_rw = n_rw; m_m2r = n_m2r; m_mw = n_mw; m_mr = n_mr;
        chk("alu_result", ALURESULT_OUT, m_res);
        chk("store_data", STOREDATA_OUT, m_sd);
        chk("ard", 32'(ARD_OUT), 32'(m_ard));
        chk("regwrite", 32'(REGWRITE_OUT), 32'(m_rw));
        chk("memtoreg", 32'(MEMTOREG_OUT), 32'(m_m2r));
        chk("memwrite", 32'(MEMWRITE_OUT), 32'(m_mw));
        chk("memread", 32'(MEMREAD_OUT), 32'(m_mr));
        $display("t=%0t op=%0d stall=%0b res=%h sd=%h rd=%0d", $time, ALUOP_IN, stall_obs,
                 ALURESULT_OUT, STOREDATA_OUT, ARD_OUT);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_res"}, ALURESULT_OUT, 32'd0);
        chk({tag, "_sd"}, STOREDATA_OUT, 32'd0);
        chk({tag, "_ard"}, 32'(ARD_OUT), 32'd0);
        chk({tag, "_ctl"}, 32'({REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT}), 32'd0);
        chk({tag, "_stall"}, 32'(STALL_OUT), 32'd0);
    endtask

    // Reset is asserted mid-cycle (away from the edge) with random inputs applied.
    task automatic apply_reset(input string tag);
        rand_instr();
        ALUOP_IN = 4'd10;
        #2;
        rst = 1'b0;
        #1;
        check_zero(tag);
        @(posedge clk);
        #1;
        rand_instr();
        #1;
        check_zero(tag);
        rst = 1'b1;
        model_clear();
        $display("t=%0t reset %s released", $time, tag);
    endtask

    initial begin
        bit s;
        int stalls, rw_seen;
        rst = 1'b1;
        model_clear();
        apply_reset("rst0");

        // ADD 5 + 3 -> x3
        set_instr(4'd0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd3, 32'h5, 32'h3, 32'h0);
        set_wb(0, 5'd0, 32'h0);
        cycle(s);
        chk("add_res", ALURESULT_OUT, 32'h8);
        chk("add_ard", 32'(ARD_OUT), 32'd3);

        // SUB forwarding from EX/MEM: x3(8) - 2
        set_instr(4'd1, 0, 1, 0, 0, 0, 5'd3, 5'd5, 5'd7, 32'h0, 32'h2, 32'h0);
        cycle(s);
        chk("fwd_exmem", ALURESULT_OUT, 32'h6);

        // Only MEM/WB matches x3: 0x10 - 2, result written to x3
        set_instr(4'd1, 0, 1, 0, 0, 0, 5'd3, 5'd5, 5'd3, 32'h0, 32'h2, 32'h0);
        set_wb(1, 5'd3, 32'h10);
        cycle(s);
        chk("fwd_wb", ALURESULT_OUT, 32'hE);

        // Both match: EX/MEM (0xE) wins over MEM/WB (0x10)
        set_instr(4'd1, 0, 1, 0, 0, 0, 5'd3, 5'd5, 5'd6, 32'h0, 32'h2, 32'h0);
        cycle(s);
        chk("fwd_prio", ALURESULT_OUT, 32'hC);

        // Store data forwarded from EX/MEM
        set_instr(4'd0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd9, 32'hDEADBEEF, 32'h0, 32'h0);
        set_wb(0, 5'd0, 32'h0);
        cycle(s);
        set_instr(4'd0, 1, 0, 0, 1, 0, 5'd0, 5'd9, 5'd0, 32'h100, 32'h0, 32'h4);
        cycle(s);
        chk("sw_data", STOREDATA_OUT, 32'hDEADBEEF);
        chk("sw_addr", ALURESULT_OUT, 32'h104);
        chk("sw_mw", 32'(MEMWRITE_OUT), 32'd1);

        // MUL 0x10000 * 0x10001 with WB noise during BUSY
        set_instr(4'd10, 0, 1, 0, 0, 0, 5'd1, 5'd2, 5'd5, 32'h00010000, 32'h00010001, 32'h0);
        set_wb(0, 5'd0, 32'h0);
        stalls = 0;
        rw_seen = 0;
        for (int i = 0; i < 34; i++) begin
            cycle(s);
            if (s) stalls++;
            if (REGWRITE_OUT) rw_seen++;
            rand_wb();
        end
        chk("mul_stalls", 32'(stalls), 32'd33);
        chk("mul_once", 32'(rw_seen), 32'd1);
        chk("mul_res", ALURESULT_OUT, 32'h00010000);
        chk("mul_ard", 32'(ARD_OUT), 32'd5);

        // Reset during BUSY step 10 abandons the multiply
        set_instr(4'd10, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd4, $urandom, $urandom, 32'h0);
        set_wb(0, 5'd0, 32'h0);
        for (int i = 0; i < 11; i++) cycle(s);
        apply_reset("rst_mul");
        set_instr(4'd0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd4, 32'h1, 32'h1, 32'h0);
        set_wb(0, 5'd0, 32'h0);
        cycle(s);
        chk("post_rst_add", ALURESULT_OUT, 32'h2);
        chk("post_rst_rw", 32'(REGWRITE_OUT), 32'd1);

        // Random instruction stream; ID/EX held while the stage stalls
        for (int n = 0; n < 250; n++) begin
            rand_instr();
            cycle(s);
            while (m_pend) begin
                rand_wb();
                cycle(s);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
